// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, instruction alignment and fetch FSM states.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID,
        FAULT
    } fetch_state_t;

    function automatic logic is_instr_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] & INSTR_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and hands
// each fetched word to decode over a valid/ready handshake.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    input  logic            instr_ready,
    input  logic [XLEN-1:0] pc_next,
    output logic            fault,
    output logic [XLEN-1:0] instr_count
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    count_d = count_q + 1'b1;
                    // A misaligned target is counted as accepted but never fetched.
                    if (is_instr_aligned(pc_next)) begin
                        pc_d    = pc_next;
                        state_d = FETCH;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    // Outputs are decoded from registered state only, so they cannot glitch on input changes.
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == VALID);
    assign fault       = (state_q == FAULT);
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign instr_count = count_q;

endmodule
